// File: rtl/blowfish_pkg.sv
// Shared types and defaults for the key-expansion engine: FSM state encoding,
// default parameter values and the salt-word selector.
package blowfish_pkg;

  localparam int unsigned PEntriesDefault  = 18;
  localparam int unsigned SboxWordsDefault = 1024;
  localparam int unsigned AddrWDefault     = 12;
  localparam int unsigned PBaseDefault     = 1024;
  localparam int unsigned KeyMaxDefault    = 72;

  typedef enum logic [2:0] {
    StIdle,
    StPRead,
    StKeyFetch,
    StPWrite,
    StEncStart,
    StEncWait,
    StWriteback,
    StDone
  } state_e;

  // Word 0 is the most significant 32 bits of the salt.
  function automatic logic [31:0] salt_word(input logic [127:0] salt, input logic [1:0] idx);
    logic [31:0] w;
    unique case (idx)
      2'd0:    w = salt[127:96];
      2'd1:    w = salt[95:64];
      2'd2:    w = salt[63:32];
      default: w = salt[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/key_stream.sv
// Cyclic key-byte stream: wrapping byte index into the key and big-endian
// assembly of eight bytes into a 64-bit word (two P entries).
module key_stream (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        advance,
  input  logic [6:0]  key_len,
  input  logic [7:0]  key_byte,
  output logic [6:0]  key_addr,
  output logic [63:0] word
);

  logic [6:0]  idx_q, idx_d;
  logic [63:0] word_q, word_d;
  logic [7:0]  byte_eff;

  always_comb begin
    idx_d    = idx_q;
    word_d   = word_q;
    // An empty key contributes zeros and never moves the index.
    byte_eff = (key_len == 7'd0) ? 8'd0 : key_byte;
    if (clear) begin
      idx_d  = '0;
      word_d = '0;
    end else if (advance) begin
      word_d = {word_q[55:0], byte_eff};
      if ((key_len == 7'd0) || (idx_q == key_len - 7'd1)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + 7'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign key_addr = idx_q;
  assign word     = word_q;

endmodule

// File: rtl/expand_state_engine.sv
// Key-expansion sequencer: XORs the key stream into the P-array, then drives an
// external encipher unit to refill P and the S-boxes. Optional EXPAND_CYCLE_CNT_EN
// adds a busy-cycle counter output.
module expand_state_engine import blowfish_pkg::*; #(
  parameter int unsigned P_ENTRIES  = PEntriesDefault,
  parameter int unsigned SBOX_WORDS = SboxWordsDefault,
  parameter int unsigned ADDR_W     = AddrWDefault,
  parameter int unsigned P_BASE     = PBaseDefault,
  parameter int unsigned KEY_MAX    = KeyMaxDefault
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [6:0]        key_len,
  input  logic [127:0]      salt,
  output logic [6:0]        key_addr,
  input  logic [7:0]        key_byte,
  output logic [ADDR_W-1:0] mem_addr_a,
  output logic [ADDR_W-1:0] mem_addr_b,
  output logic              mem_we,
  output logic [31:0]       mem_wdata_a,
  output logic [31:0]       mem_wdata_b,
  input  logic [31:0]       mem_rdata_a,
  input  logic [31:0]       mem_rdata_b,
  output logic              mem_grant,
  output logic              enc_start,
  output logic [31:0]       enc_l,
  output logic [31:0]       enc_r,
  input  logic              enc_done,
  input  logic [31:0]       enc_res_l,
  input  logic [31:0]       enc_res_r,
  output logic              busy,
  output logic              done
`ifdef EXPAND_CYCLE_CNT_EN
  ,
  output logic [31:0]       cycle_count
`endif
);

  localparam int unsigned NumPairs = P_ENTRIES / 2;
  localparam int unsigned NumEnc   = NumPairs + SBOX_WORDS / 2;
  localparam int unsigned EncW     = $clog2(NumEnc + 1);
  localparam logic [EncW-1:0] LastPair = EncW'(NumPairs - 1);
  localparam logic [EncW-1:0] LastEnc  = EncW'(NumEnc - 1);
  localparam logic [6:0]      KeyMaxW  = 7'(KEY_MAX);

  state_e            state_q, state_d;
  logic [EncW-1:0]   pair_q, pair_d;
  logic [EncW-1:0]   enc_q, enc_d;
  logic [2:0]        byte_q, byte_d;
  logic [31:0]       pa_q, pa_d, pb_q, pb_d;
  logic [31:0]       l_q, l_d, r_q, r_d;
  logic [127:0]      salt_q, salt_d;
  logic              mode_q, mode_d;
  logic [6:0]        klen_q, klen_d;

  logic              ks_clear, ks_adv;
  logic [63:0]       ks_word;
  logic [ADDR_W-1:0] p_pair_addr, wb_addr;

  key_stream u_key_stream (
    .clk      (clk),
    .reset    (reset),
    .clear    (ks_clear),
    .advance  (ks_adv),
    .key_len  (klen_q),
    .key_byte (key_byte),
    .key_addr (key_addr),
    .word     (ks_word)
  );

  always_comb begin
    state_d  = state_q;
    pair_d   = pair_q;
    enc_d    = enc_q;
    byte_d   = byte_q;
    pa_d     = pa_q;
    pb_d     = pb_q;
    l_d      = l_q;
    r_d      = r_q;
    salt_d   = salt_q;
    mode_d   = mode_q;
    klen_d   = klen_q;
    ks_clear = 1'b0;
    ks_adv   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StPRead;
          salt_d   = salt;
          mode_d   = mode;
          klen_d   = (key_len > KeyMaxW) ? KeyMaxW : key_len;
          pair_d   = '0;
          enc_d    = '0;
          l_d      = '0;
          r_d      = '0;
          ks_clear = 1'b1;
        end
      end
      StPRead: begin
        byte_d  = '0;
        state_d = StKeyFetch;
      end
      StKeyFetch: begin
        ks_adv = 1'b1;
        // Read data from StPRead arrives in the first fetch cycle.
        if (byte_q == 3'd0) begin
          pa_d = mem_rdata_a;
          pb_d = mem_rdata_b;
        end
        byte_d = byte_q + 3'd1;
        if (byte_q == 3'd7) state_d = StPWrite;
      end
      StPWrite: begin
        if (pair_q == LastPair) begin
          state_d = StEncStart;
        end else begin
          pair_d  = pair_q + EncW'(1);
          state_d = StPRead;
        end
      end
      StEncStart: state_d = StEncWait;
      StEncWait: begin
        if (enc_done) begin
          l_d     = enc_res_l;
          r_d     = enc_res_r;
          state_d = StWriteback;
        end
      end
      StWriteback: begin
        if (enc_q == LastEnc) begin
          state_d = StDone;
        end else begin
          enc_d   = enc_q + EncW'(1);
          state_d = StEncStart;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pair_q  <= '0;
      enc_q   <= '0;
      byte_q  <= '0;
      pa_q    <= '0;
      pb_q    <= '0;
      l_q     <= '0;
      r_q     <= '0;
      salt_q  <= '0;
      mode_q  <= 1'b0;
      klen_q  <= '0;
    end else begin
      state_q <= state_d;
      pair_q  <= pair_d;
      enc_q   <= enc_d;
      byte_q  <= byte_d;
      pa_q    <= pa_d;
      pb_q    <= pb_d;
      l_q     <= l_d;
      r_q     <= r_d;
      salt_q  <= salt_d;
      mode_q  <= mode_d;
      klen_q  <= klen_d;
    end
  end

  assign p_pair_addr = ADDR_W'(P_BASE + 2 * 32'(pair_q));
  // The first NumPairs writebacks refill P, the rest fill the S-boxes from 0.
  assign wb_addr = (32'(enc_q) < NumPairs) ? ADDR_W'(P_BASE + 2 * 32'(enc_q))
                                           : ADDR_W'(2 * (32'(enc_q) - NumPairs));

  // Outputs decode registered state only.
  always_comb begin
    mem_addr_a  = '0;
    mem_addr_b  = '0;
    mem_wdata_a = '0;
    mem_wdata_b = '0;
    mem_we      = 1'b0;
    unique case (state_q)
      StPRead: begin
        mem_addr_a = p_pair_addr;
        mem_addr_b = p_pair_addr + ADDR_W'(1);
      end
      StPWrite: begin
        mem_addr_a  = p_pair_addr;
        mem_addr_b  = p_pair_addr + ADDR_W'(1);
        mem_wdata_a = pa_q ^ ks_word[63:32];
        mem_wdata_b = pb_q ^ ks_word[31:0];
        mem_we      = 1'b1;
      end
      StWriteback: begin
        mem_addr_a  = wb_addr;
        mem_addr_b  = wb_addr + ADDR_W'(1);
        mem_wdata_a = l_q;
        mem_wdata_b = r_q;
        mem_we      = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign enc_start = (state_q == StEncStart);
  assign mem_grant = (state_q == StEncStart) || (state_q == StEncWait);
  assign enc_l     = mode_q ? l_q : (l_q ^ salt_word(salt_q, {enc_q[0], 1'b0}));
  assign enc_r     = mode_q ? r_q : (r_q ^ salt_word(salt_q, {enc_q[0], 1'b1}));

`ifdef EXPAND_CYCLE_CNT_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (state_q == StIdle) begin
      if (start) cyc_d = '0;
    end else begin
      cyc_d = cyc_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cyc_q <= '0;
    else       cyc_q <= cyc_d;
  end

  assign cycle_count = cyc_q;
`endif

endmodule

// File: tb/tb_expand_state_engine.sv
// Directed bench for expand_state_engine with memory, key ROM and an
// inputs-plus-one encipher model.
module tb_expand_state_engine;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [6:0]   key_len = '0;
  logic [127:0] salt = '0;
  logic [6:0]   key_addr;
  logic [7:0]   key_byte;
  logic [11:0]  mem_addr_a, mem_addr_b;
  logic         mem_we;
  logic [31:0]  mem_wdata_a, mem_wdata_b;
  logic [31:0]  mem_rdata_a = '0, mem_rdata_b = '0;
  logic         mem_grant;
  logic         enc_start;
  logic [31:0]  enc_l, enc_r;
  logic         enc_done = 1'b0;
  logic [31:0]  enc_res_l = '0, enc_res_r = '0;
  logic         busy, done;
`ifdef EXPAND_CYCLE_CNT_EN
  logic [31:0]  cycle_count;
`endif

  expand_state_engine dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .key_len     (key_len),
    .salt        (salt),
    .key_addr    (key_addr),
    .key_byte    (key_byte),
    .mem_addr_a  (mem_addr_a),
    .mem_addr_b  (mem_addr_b),
    .mem_we      (mem_we),
    .mem_wdata_a (mem_wdata_a),
    .mem_wdata_b (mem_wdata_b),
    .mem_rdata_a (mem_rdata_a),
    .mem_rdata_b (mem_rdata_b),
    .mem_grant   (mem_grant),
    .enc_start   (enc_start),
    .enc_l       (enc_l),
    .enc_r       (enc_r),
    .enc_done    (enc_done),
    .enc_res_l   (enc_res_l),
    .enc_res_r   (enc_res_r),
    .busy        (busy),
    .done        (done)
`ifdef EXPAND_CYCLE_CNT_EN
    ,
    .cycle_count (cycle_count)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:4095];
  logic [7:0]  key_mem [0:127];
  logic        mem_clr = 1'b0;

  assign key_byte = key_mem[key_addr];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[mem_addr_a] <= mem_wdata_a;
      mem[mem_addr_b] <= mem_wdata_b;
    end
    mem_rdata_a <= mem[mem_addr_a];
    mem_rdata_b <= mem[mem_addr_b];
  end

  always @(posedge clk) begin
    enc_done  <= enc_start;
    enc_res_l <= enc_l + 32'd1;
    enc_res_r <= enc_r + 32'd1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Per-run observations
  logic [11:0] wr_addr [0:599];
  logic [31:0] wr_a [0:599];
  logic [31:0] wr_b [0:599];
  int          wr_n, enc_n, done_n, overlap, addr_bad, busy_cyc, max_ka;
  logic [31:0] el0, er0;

  task automatic run_op(input logic m, input logic [6:0] kl, input logic [127:0] s,
                        input logic kind, input logic poke);
    bit got_done;
    int exp_ka;
    for (int i = 0; i < 128; i++) begin
      if (kind) key_mem[i] = 8'(i);
      else key_mem[i] = (i % 3 == 0) ? 8'h61 : ((i % 3 == 1) ? 8'h62 : 8'h63);
    end
    mem_clr = 1'b1;
    @(negedge clk);
    mem_clr = 1'b0;
    mode = m; key_len = kl; salt = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr_n = 0; enc_n = 0; done_n = 0; overlap = 0; addr_bad = 0; busy_cyc = 0; max_ka = 0;
    el0 = 'x; er0 = 'x; got_done = 0;
    for (int c = 0; c < 5000 && !got_done; c++) begin
      if (busy) busy_cyc++;
      if (mem_we) begin
        if (wr_n < 600) begin
          wr_addr[wr_n] = mem_addr_a; wr_a[wr_n] = mem_wdata_a; wr_b[wr_n] = mem_wdata_b;
        end
        wr_n++;
        if (mem_grant) overlap++;
        if (mem_addr_b != mem_addr_a + 12'd1) addr_bad++;
      end
      if (enc_start) begin
        if (enc_n == 0) begin el0 = enc_l; er0 = enc_r; end
        enc_n++;
      end
      if (int'(key_addr) > max_ka) max_ka = int'(key_addr);
      if (done) begin done_n++; got_done = 1; end
      start = (poke && (c == 3 || c == 800)) ? 1'b1 : 1'b0;
      if (!got_done) @(negedge clk);
    end
    start = 1'b0;
    chk("done_seen", 32'(got_done), 32'd1);
    repeat (4) begin
      @(negedge clk);
      if (done) done_n++;
    end
    chk("done_pulses", done_n, 1);
    chk("busy_after", 32'(busy), 32'd0);
    chk("enc_count", enc_n, 521);
    chk("write_count", wr_n, 530);
    chk("we_during_grant", overlap, 0);
    chk("lane_b_addr", addr_bad, 0);
    chk("busy_cycles", busy_cyc, 1654);
    exp_ka = (kl > 7'd72) ? 71 : ((kl == 7'd0) ? 0 : int'(kl) - 1);
    chk("max_key_addr", max_ka, exp_ka);
`ifdef EXPAND_CYCLE_CNT_EN
    chk("cycle_count", cycle_count, busy_cyc);
`endif
  endtask

  typedef struct {
    logic         mode;
    logic [6:0]   klen;
    logic [127:0] salt;
    logic         kind;   // 0: "abc" repeated, 1: byte i = i
    int           widx;
    logic [11:0]  addr;
    logic [31:0]  a;
    logic [31:0]  b;
    logic [31:0]  el0;
    logic [31:0]  er0;
  } vec_t;

  localparam logic [127:0] Salt4 = 128'h00000001_00000002_00000003_00000004;

  vec_t vecs [12];
  int   n_before;

  initial begin
    vecs[0]  = '{1'b1, 7'd3,   '0,    1'b0, 0,   12'd1024, 32'h61626361, 32'h62636162, 0, 0};
    vecs[1]  = '{1'b1, 7'd3,   '0,    1'b0, 1,   12'd1026, 32'h63616263, 32'h61626361, 0, 0};
    vecs[2]  = '{1'b1, 7'd72,  '0,    1'b1, 0,   12'd1024, 32'h00010203, 32'h04050607, 0, 0};
    vecs[3]  = '{1'b1, 7'd100, '0,    1'b1, 8,   12'd1040, 32'h40414243, 32'h44454647, 0, 0};
    vecs[4]  = '{1'b1, 7'd72,  '0,    1'b1, 8,   12'd1040, 32'h40414243, 32'h44454647, 0, 0};
    vecs[5]  = '{1'b1, 7'd0,   '0,    1'b0, 4,   12'd1032, 32'h0,        32'h0,        0, 0};
    vecs[6]  = '{1'b1, 7'd3,   '0,    1'b0, 9,   12'd1024, 32'd1,        32'd1,        0, 0};
    vecs[7]  = '{1'b1, 7'd3,   '0,    1'b0, 18,  12'd0,    32'd10,       32'd10,       0, 0};
    vecs[8]  = '{1'b1, 7'd3,   '0,    1'b0, 529, 12'd1022, 32'd521,      32'd521,      0, 0};
    vecs[9]  = '{1'b0, 7'd3,   Salt4, 1'b0, 9,   12'd1024, 32'd2,        32'd3,        1, 2};
    vecs[10] = '{1'b0, 7'd3,   Salt4, 1'b0, 10,  12'd1026, 32'd2,        32'd8,        1, 2};
    vecs[11] = '{1'b0, 7'd3,   Salt4, 1'b0, 11,  12'd1028, 32'd4,        32'd11,       1, 2};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_grant", 32'(mem_grant), 0);
    chk("rst_enc_start", 32'(enc_start), 0);
    chk("rst_addr_a", 32'(mem_addr_a), 0);
    chk("rst_key_addr", 32'(key_addr), 0);
    chk("rst_enc_l", enc_l, 0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[v]) begin
      run_op(vecs[v].mode, vecs[v].klen, vecs[v].salt, vecs[v].kind, 1'b0);
      chk($sformatf("v%0d_addr", v), 32'(wr_addr[vecs[v].widx]), 32'(vecs[v].addr));
      chk($sformatf("v%0d_wdata_a", v), wr_a[vecs[v].widx], vecs[v].a);
      chk($sformatf("v%0d_wdata_b", v), wr_b[vecs[v].widx], vecs[v].b);
      chk($sformatf("v%0d_enc_l0", v), el0, vecs[v].el0);
      chk($sformatf("v%0d_enc_r0", v), er0, vecs[v].er0);
    end

    // Reset during the 100th ENC_WAIT
    mode = 1'b1; key_len = 7'd3; salt = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    enc_n = 0;
    for (int c = 0; c < 3000 && enc_n < 100; c++) begin
      if (enc_start) enc_n++;
      if (enc_n < 100) @(negedge clk);
    end
    chk("abort_enc_reached", enc_n, 100);
    @(negedge clk);
    chk("abort_in_wait", 32'(mem_grant), 1);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_grant", 32'(mem_grant), 0);
    @(posedge clk);
    #1;
    chk("abort_we_edge", 32'(mem_we), 0);
    @(negedge clk);
    reset = 1'b0;
    n_before = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_we || done || busy) n_before++;
    end
    chk("abort_quiet", n_before, 0);

    // Fresh run after abort, with start pulsed while busy
    run_op(1'b1, 7'd3, '0, 1'b0, 1'b1);
    chk("restart_first_addr", 32'(wr_addr[0]), 32'd1024);
    chk("restart_last_addr", 32'(wr_addr[529]), 32'd1022);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
